// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the 5-stage pipeline control unit:
// PC source selects, CP0 exception codes, FSM states and per-cycle actions.
package pipe_ctrl_pkg;

    localparam logic [3:0] PC_SRC_JUMP = 4'd0;
    localparam logic [3:0] PC_SRC_JR   = 4'd1;
    localparam logic [3:0] PC_SRC_VEC  = 4'd2;
    localparam logic [3:0] PC_SRC_EPC  = 4'd3;
    localparam logic [3:0] PC_SRC_FIX  = 4'd4;
    localparam logic [3:0] PC_SRC_SEQ  = 4'd5;

    localparam logic [4:0] EXC_INT = 5'd0;
    localparam logic [4:0] EXC_SYS = 5'd8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PEND,
        ST_TAKE,
        ST_HANDLER
    } ctrl_state_t;

    // One winner per cycle, chosen by the priority chain in the top.
    typedef enum logic [3:0] {
        ACT_STALL,
        ACT_TAKE,
        ACT_PEND_GO,
        ACT_EXC,
        ACT_BRANCH,
        ACT_ERET,
        ACT_JR,
        ACT_JUMP,
        ACT_LU,
        ACT_NONE
    } ctrl_act_t;

endpackage

// File: rtl/pipe_ctrl_fsm_irq_prio_enc.sv
// Masked interrupt priority encoder; the lowest set index wins.
module irq_prio_enc #(
    parameter int NUM_IRQ = 6,
    parameter int IW      = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic [NUM_IRQ-1:0] req,
    output logic               valid,
    output logic [IW-1:0]      idx
);

    always_comb begin
        valid = |req;
        idx   = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (req[i]) idx = IW'(i);
        end
    end

endmodule

// File: rtl/pipe_ctrl_fsm.sv
// Pipeline control unit: hazard stalls/flushes, PC redirects and the
// exception entry FSM that defers across mem_stall and strobes CP0 once.
module pipe_ctrl_fsm #(
    parameter int          XLEN       = 32,
    parameter int          NUM_IRQ    = 6,
    parameter int          LU_LAT     = 1,
    parameter logic [31:0] EXC_VECTOR = 32'h8000_0180,
    localparam int         IW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               id_jump,
    input  logic               id_jr,
    input  logic [4:0]         ifid_rs_addr,
    input  logic [4:0]         ifid_rt_addr,
    input  logic [4:0]         idex_rd_addr,
    input  logic               idex_mem_read,
    input  logic [XLEN-1:0]    predicted_ifid_pc,
    input  logic [XLEN-1:0]    predicted_idex_pc,
    input  logic [XLEN-1:0]    target_exmem_pc,
    input  logic               ex_nop,
    input  logic               mem_nop,
    input  logic               mem_jmp,
    input  logic               exmem_syscall,
    input  logic               exmem_eret,
    input  logic               mem_stall,
    input  logic [NUM_IRQ-1:0] irq_pending,
    input  logic [NUM_IRQ-1:0] irq_mask,
    output logic [3:0]         cu_pc_src,
    output logic               cu_pc_stall,
    output logic               cu_ifid_stall,
    output logic               cu_idex_stall,
    output logic               cu_exmem_stall,
    output logic               cu_ifid_flush,
    output logic               cu_idex_flush,
    output logic               cu_exmem_flush,
    output logic               cu_cp0_w_en,
    output logic [4:0]         cu_exec_code,
    output logic [XLEN-1:0]    cu_epc,
    output logic [XLEN-1:0]    cu_vector,
    output logic [IW-1:0]      cu_irq_id,
    output logic               bpu_write_en,
    output logic               cu_in_handler
);

    import pipe_ctrl_pkg::*;

    ctrl_state_t     state;
    ctrl_act_t       act;
    logic [2:0]      lu_cnt;
    logic [4:0]      code_q;
    logic [XLEN-1:0] epc_q;
    logic [IW-1:0]   irq_id_q;

    logic [NUM_IRQ-1:0] irq_act;
    logic               irq_valid;
    logic [IW-1:0]      irq_idx;

    logic load_use;
    logic branch_haz;
    logic irq_req;
    logic exc_req;
    logic lu_busy;
    logic can_enter;

    assign irq_act = irq_pending & irq_mask;

    irq_prio_enc #(
        .NUM_IRQ (NUM_IRQ),
        .IW      (IW)
    ) u_prio (
        .req   (irq_act),
        .valid (irq_valid),
        .idx   (irq_idx)
    );

    assign load_use = idex_mem_read &
                      ((idex_rd_addr == ifid_rs_addr) |
                       (idex_rd_addr == ifid_rt_addr));

    assign branch_haz =
        (!ex_nop && !mem_nop &&
         predicted_idex_pc != target_exmem_pc) ||
        (ex_nop && !mem_nop && !mem_jmp &&
         predicted_ifid_pc != target_exmem_pc);

    assign irq_req   = (state == ST_IDLE) & irq_valid;
    assign exc_req   = exmem_syscall | irq_req;
    assign lu_busy   = load_use | (lu_cnt != 3'd0);
    assign can_enter = (state == ST_IDLE) | (state == ST_HANDLER);

    always_comb begin
        act = ACT_NONE;
        if (mem_stall)                act = ACT_STALL;
        else if (state == ST_TAKE)    act = ACT_TAKE;
        else if (state == ST_PEND)    act = ACT_PEND_GO;
        else if (exc_req)             act = ACT_EXC;
        else if (branch_haz)          act = ACT_BRANCH;
        else if (exmem_eret)          act = ACT_ERET;
        else if (id_jr)               act = ACT_JR;
        else if (id_jump)             act = ACT_JUMP;
        else if (lu_busy)             act = ACT_LU;
    end

    always_comb begin
        cu_pc_src      = PC_SRC_SEQ;
        cu_pc_stall    = 1'b0;
        cu_ifid_stall  = 1'b0;
        cu_idex_stall  = 1'b0;
        cu_exmem_stall = 1'b0;
        cu_ifid_flush  = 1'b0;
        cu_idex_flush  = 1'b0;
        cu_exmem_flush = 1'b0;
        cu_cp0_w_en    = 1'b0;
        bpu_write_en   = 1'b0;
        unique case (act)
            ACT_STALL: begin
                cu_pc_stall    = 1'b1;
                cu_ifid_stall  = 1'b1;
                cu_idex_stall  = 1'b1;
                cu_exmem_stall = 1'b1;
            end
            ACT_TAKE: begin
                cu_cp0_w_en    = 1'b1;
                cu_pc_src      = PC_SRC_VEC;
                cu_ifid_flush  = 1'b1;
                cu_idex_flush  = 1'b1;
                cu_exmem_flush = 1'b1;
            end
            ACT_PEND_GO, ACT_EXC: begin
                cu_pc_stall    = 1'b1;
                cu_ifid_flush  = 1'b1;
                cu_idex_flush  = 1'b1;
                cu_exmem_flush = 1'b1;
            end
            ACT_BRANCH: begin
                cu_pc_src      = PC_SRC_FIX;
                cu_ifid_flush  = 1'b1;
                cu_idex_flush  = 1'b1;
                cu_exmem_flush = 1'b1;
                bpu_write_en   = 1'b1;
            end
            ACT_ERET: cu_pc_src = PC_SRC_EPC;
            ACT_JR: begin
                cu_pc_src     = PC_SRC_JR;
                cu_ifid_flush = 1'b1;
            end
            ACT_JUMP: begin
                cu_pc_src     = PC_SRC_JUMP;
                cu_ifid_flush = 1'b1;
            end
            ACT_LU: begin
                cu_pc_stall   = 1'b1;
                cu_ifid_stall = 1'b1;
                cu_idex_flush = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            lu_cnt   <= 3'd0;
            code_q   <= 5'd0;
            epc_q    <= '0;
            irq_id_q <= '0;
        end else begin
            unique case (act)
                ACT_STALL: begin
                    if (exc_req && can_enter) begin
                        state    <= ST_PEND;
                        code_q   <= irq_req ? EXC_INT : EXC_SYS;
                        irq_id_q <= irq_req ? irq_idx : '0;
                        epc_q    <= branch_haz ? target_exmem_pc
                                               : predicted_idex_pc;
                    end
                end
                ACT_TAKE: begin
                    state  <= ST_HANDLER;
                    lu_cnt <= 3'd0;
                end
                ACT_PEND_GO: begin
                    state  <= ST_TAKE;
                    lu_cnt <= 3'd0;
                end
                ACT_EXC: begin
                    state    <= ST_TAKE;
                    lu_cnt   <= 3'd0;
                    code_q   <= irq_req ? EXC_INT : EXC_SYS;
                    irq_id_q <= irq_req ? irq_idx : '0;
                    epc_q    <= branch_haz ? target_exmem_pc
                                           : predicted_idex_pc;
                end
                ACT_ERET: begin
                    lu_cnt <= 3'd0;
                    if (state == ST_HANDLER) state <= ST_IDLE;
                end
                ACT_BRANCH, ACT_JR, ACT_JUMP: lu_cnt <= 3'd0;
                ACT_LU: begin
                    if (load_use && lu_cnt == 3'd0)
                        lu_cnt <= 3'(LU_LAT - 1);
                    else
                        lu_cnt <= lu_cnt - 3'd1;
                end
                default: ;
            endcase
        end
    end

    assign cu_exec_code  = code_q;
    assign cu_epc        = epc_q;
    assign cu_irq_id     = irq_id_q;
    assign cu_vector     = XLEN'(EXC_VECTOR);
    assign cu_in_handler = (state == ST_HANDLER);

endmodule

// File: tb/tb_pipe_ctrl_fsm.sv
// Directed bench for pipe_ctrl_fsm with a queue-based expectation scoreboard.
module tb_pipe_ctrl_fsm;

    localparam int XLEN = 32;
    localparam int NIRQ = 6;
    localparam int IW   = 3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            id_jump, id_jr;
    logic [4:0]      ifid_rs_addr, ifid_rt_addr, idex_rd_addr;
    logic            idex_mem_read;
    logic [XLEN-1:0] predicted_ifid_pc, predicted_idex_pc, target_exmem_pc;
    logic            ex_nop, mem_nop, mem_jmp;
    logic            exmem_syscall, exmem_eret, mem_stall;
    logic [NIRQ-1:0] irq_pending, irq_mask;
    logic [3:0]      cu_pc_src;
    logic            cu_pc_stall, cu_ifid_stall, cu_idex_stall, cu_exmem_stall;
    logic            cu_ifid_flush, cu_idex_flush, cu_exmem_flush;
    logic            cu_cp0_w_en;
    logic [4:0]      cu_exec_code;
    logic [XLEN-1:0] cu_epc, cu_vector;
    logic [IW-1:0]   cu_irq_id;
    logic            bpu_write_en, cu_in_handler;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [3:0]  src;
        logic [3:0]  st;
        logic [2:0]  fl;
        logic        cp0;
        logic        bpu;
        logic        hnd;
        logic        chk_exc;
        logic        chk_irq;
        logic [4:0]  code;
        logic [31:0] epc;
        logic [2:0]  irq;
    } exp_t;

    exp_t q[$];

    pipe_ctrl_fsm #(
        .XLEN       (XLEN),
        .NUM_IRQ    (NIRQ),
        .LU_LAT     (2),
        .EXC_VECTOR (32'h8000_0180)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .id_jump           (id_jump),
        .id_jr             (id_jr),
        .ifid_rs_addr      (ifid_rs_addr),
        .ifid_rt_addr      (ifid_rt_addr),
        .idex_rd_addr      (idex_rd_addr),
        .idex_mem_read     (idex_mem_read),
        .predicted_ifid_pc (predicted_ifid_pc),
        .predicted_idex_pc (predicted_idex_pc),
        .target_exmem_pc   (target_exmem_pc),
        .ex_nop            (ex_nop),
        .mem_nop           (mem_nop),
        .mem_jmp           (mem_jmp),
        .exmem_syscall     (exmem_syscall),
        .exmem_eret        (exmem_eret),
        .mem_stall         (mem_stall),
        .irq_pending       (irq_pending),
        .irq_mask          (irq_mask),
        .cu_pc_src         (cu_pc_src),
        .cu_pc_stall       (cu_pc_stall),
        .cu_ifid_stall     (cu_ifid_stall),
        .cu_idex_stall     (cu_idex_stall),
        .cu_exmem_stall    (cu_exmem_stall),
        .cu_ifid_flush     (cu_ifid_flush),
        .cu_idex_flush     (cu_idex_flush),
        .cu_exmem_flush    (cu_exmem_flush),
        .cu_cp0_w_en       (cu_cp0_w_en),
        .cu_exec_code      (cu_exec_code),
        .cu_epc            (cu_epc),
        .cu_vector         (cu_vector),
        .cu_irq_id         (cu_irq_id),
        .bpu_write_en      (bpu_write_en),
        .cu_in_handler     (cu_in_handler)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic exp_t mk(input string tag, input logic [3:0] src,
                                input logic [3:0] st, input logic [2:0] fl,
                                input logic cp0, input logic bpu,
                                input logic hnd);
        exp_t e;
        e.tag = tag; e.src = src; e.st = st; e.fl = fl;
        e.cp0 = cp0; e.bpu = bpu; e.hnd = hnd;
        e.chk_exc = 1'b0; e.chk_irq = 1'b0;
        e.code = 5'd0; e.epc = 32'd0; e.irq = 3'd0;
        return e;
    endfunction

    function automatic exp_t mk_take(input string tag, input logic [4:0] code,
                                     input logic [31:0] epc,
                                     input logic chk_irq, input logic [2:0] irq);
        exp_t e;
        e = mk(tag, 4'd2, 4'b0000, 3'b111, 1'b1, 1'b0, 1'b0);
        e.chk_exc = 1'b1; e.code = code; e.epc = epc;
        e.chk_irq = chk_irq; e.irq = irq;
        return e;
    endfunction

    // Push at drive time, pop at the negedge sample point.
    task automatic step(input exp_t e);
        exp_t g;
        q.push_back(e);
        @(negedge clk);
        g = q.pop_front();
        chk({g.tag, ".pc_src"}, 32'(cu_pc_src), 32'(g.src));
        chk({g.tag, ".stall"},
            32'({cu_pc_stall, cu_ifid_stall, cu_idex_stall, cu_exmem_stall}),
            32'(g.st));
        chk({g.tag, ".flush"},
            32'({cu_ifid_flush, cu_idex_flush, cu_exmem_flush}), 32'(g.fl));
        chk({g.tag, ".cp0_w_en"}, 32'(cu_cp0_w_en), 32'(g.cp0));
        chk({g.tag, ".bpu_write_en"}, 32'(bpu_write_en), 32'(g.bpu));
        chk({g.tag, ".in_handler"}, 32'(cu_in_handler), 32'(g.hnd));
        chk({g.tag, ".vector"}, cu_vector, 32'h8000_0180);
        if (g.chk_exc) begin
            chk({g.tag, ".exec_code"}, 32'(cu_exec_code), 32'(g.code));
            chk({g.tag, ".epc"}, cu_epc, g.epc);
        end
        if (g.chk_irq) chk({g.tag, ".irq_id"}, 32'(cu_irq_id), 32'(g.irq));
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        id_jump = 0; id_jr = 0;
        ifid_rs_addr = 5'd1; ifid_rt_addr = 5'd2; idex_rd_addr = 5'd0;
        idex_mem_read = 0;
        predicted_ifid_pc = 32'h44;
        predicted_idex_pc = 32'h40;
        target_exmem_pc   = 32'h40;
        ex_nop = 0; mem_nop = 0; mem_jmp = 0;
        exmem_syscall = 0; exmem_eret = 0; mem_stall = 0;
        irq_pending = '0; irq_mask = 6'h3f;
    endtask

    initial begin
        exp_t e;
        rst_n = 1'b0;
        quiet();
        e = mk("reset", 4'd5, 4'b0000, 3'b000, 0, 0, 0);
        e.chk_exc = 1; e.chk_irq = 1;
        step(e);
        rst_n = 1'b1;
        step(mk("idle", 4'd5, 4'b0000, 3'b000, 0, 0, 0));

        idex_mem_read = 1; idex_rd_addr = 5'd3; ifid_rs_addr = 5'd3;
        step(mk("lu1", 4'd5, 4'b1100, 3'b010, 0, 0, 0));
        quiet();
        step(mk("lu2", 4'd5, 4'b1100, 3'b010, 0, 0, 0));
        step(mk("lu_done", 4'd5, 4'b0000, 3'b000, 0, 0, 0));

        idex_mem_read = 1; idex_rd_addr = 5'd3;
        ifid_rs_addr = 5'd9; ifid_rt_addr = 5'd3;
        step(mk("lu_rt", 4'd5, 4'b1100, 3'b010, 0, 0, 0));
        quiet();
        predicted_idex_pc = 32'h100; target_exmem_pc = 32'h200;
        step(mk("mispred", 4'd4, 4'b0000, 3'b111, 0, 1, 0));
        quiet();
        step(mk("lu_cleared", 4'd5, 4'b0000, 3'b000, 0, 0, 0));

        ex_nop = 1; predicted_ifid_pc = 32'h300;
        step(mk("mispred_ifid", 4'd4, 4'b0000, 3'b111, 0, 1, 0));
        mem_jmp = 1; predicted_idex_pc = 32'h100;
        step(mk("mem_jmp_ok", 4'd5, 4'b0000, 3'b000, 0, 0, 0));
        quiet();

        id_jr = 1; id_jump = 1;
        step(mk("jr", 4'd1, 4'b0000, 3'b100, 0, 0, 0));
        id_jr = 0;
        step(mk("jump", 4'd0, 4'b0000, 3'b100, 0, 0, 0));
        quiet(); exmem_eret = 1;
        step(mk("eret_idle", 4'd3, 4'b0000, 3'b000, 0, 0, 0));
        quiet();

        irq_pending = 6'b000110; irq_mask = 6'b111100;
        step(mk("irq_req", 4'd5, 4'b1000, 3'b111, 0, 0, 0));
        step(mk_take("irq_take", 5'd0, 32'h40, 1, 3'd2));
        step(mk("irq_hnd", 4'd5, 4'b0000, 3'b000, 0, 0, 1));
        irq_pending = 6'b000001; irq_mask = 6'h3f;
        step(mk("hnd_irq_ign", 4'd5, 4'b0000, 3'b000, 0, 0, 1));
        quiet(); exmem_eret = 1;
        step(mk("eret_hnd", 4'd3, 4'b0000, 3'b000, 0, 0, 1));
        quiet();
        step(mk("after_eret", 4'd5, 4'b0000, 3'b000, 0, 0, 0));
        irq_pending = 6'b000001; irq_mask = 6'b111110;
        step(mk("irq_masked", 4'd5, 4'b0000, 3'b000, 0, 0, 0));
        irq_mask = 6'h3f;
        step(mk("irq0_req", 4'd5, 4'b1000, 3'b111, 0, 0, 0));
        quiet();
        step(mk_take("irq0_take", 5'd0, 32'h40, 1, 3'd0));
        step(mk("irq0_hnd", 4'd5, 4'b0000, 3'b000, 0, 0, 1));
        exmem_eret = 1;
        step(mk("eret2", 4'd3, 4'b0000, 3'b000, 0, 0, 1));
        quiet();
        step(mk("idle2", 4'd5, 4'b0000, 3'b000, 0, 0, 0));

        exmem_syscall = 1; mem_stall = 1;
        predicted_idex_pc = 32'h1234; target_exmem_pc = 32'h1234;
        for (int i = 1; i <= 3; i++)
            step(mk($sformatf("sys_stall%0d", i), 4'd5, 4'b1111, 3'b000,
                    0, 0, 0));
        mem_stall = 0;
        step(mk("sys_rel", 4'd5, 4'b1000, 3'b111, 0, 0, 0));
        quiet();
        step(mk_take("sys_take", 5'd8, 32'h1234, 0, 3'd0));
        step(mk("sys_hnd", 4'd5, 4'b0000, 3'b000, 0, 0, 1));

        exmem_syscall = 1;
        predicted_idex_pc = 32'h500; target_exmem_pc = 32'h600;
        step(mk("sysbr_req", 4'd5, 4'b1000, 3'b111, 0, 0, 1));
        quiet();
        step(mk_take("sysbr_take", 5'd8, 32'h600, 0, 3'd0));
        step(mk("sysbr_hnd", 4'd5, 4'b0000, 3'b000, 0, 0, 1));

        exmem_eret = 1;
        step(mk("eret3", 4'd3, 4'b0000, 3'b000, 0, 0, 1));
        quiet(); irq_pending = 6'b000100;
        predicted_idex_pc = 32'h77; target_exmem_pc = 32'h77;
        step(mk("irq3_req", 4'd5, 4'b1000, 3'b111, 0, 0, 0));
        quiet(); rst_n = 1'b0;
        e = mk("rst_take", 4'd5, 4'b0000, 3'b000, 0, 0, 0);
        e.chk_exc = 1; e.chk_irq = 1;
        step(e);
        rst_n = 1'b1;
        step(mk("post_rst", 4'd5, 4'b0000, 3'b000, 0, 0, 0));
        irq_pending = 6'b000001;
        step(mk("post_rst_req", 4'd5, 4'b1000, 3'b111, 0, 0, 0));
        quiet();
        step(mk_take("post_rst_take", 5'd0, 32'h40, 1, 3'd0));

        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
